// File: rtl/em_degauss_driver.sv
// em_degauss_driver: multi-channel electromagnet H-bridge controller with latched hold drive
// and a decaying alternating-polarity degauss release. Optional bridge dead-time: `define EM_DEADTIME_EN.
module em_degauss_driver #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 27,
  parameter int START_PERIOD = 1000000,
  parameter int STEP         = 100000,
  parameter int DEAD_CYC     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   hold_req,
  input  logic [NUM_CH-1:0]   release_req,
  output logic [2*NUM_CH-1:0] coil,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DEGAUSS = 2'd2
  } state_e;

  localparam logic [1:0]       COIL_OFF    = 2'b00;
  localparam logic [1:0]       COIL_FWD    = 2'b01;
  localparam logic [1:0]       COIL_REV    = 2'b10;
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0] PERIOD_STEP = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (START_PERIOD < 1 || STEP < 1 || DEAD_CYC < 0) begin : g_param_check
    $error("em_degauss_driver: START_PERIOD and STEP must be >= 1, DEAD_CYC >= 0");
  end

  state_e              state_q  [NUM_CH];
  state_e              state_d  [NUM_CH];
  logic [CNT_W-1:0]    period_q [NUM_CH];
  logic [CNT_W-1:0]    period_d [NUM_CH];
  logic [CNT_W-1:0]    cnt_q    [NUM_CH];
  logic [CNT_W-1:0]    cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]   rev_q, rev_d;
  logic [NUM_CH-1:0]   release_q, release_d;
  logic [NUM_CH-1:0]   busy_q, busy_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [2*NUM_CH-1:0] coil_q, coil_d;
  logic [NUM_CH-1:0]   rel_edge;
  logic                in_dead;

`ifdef EM_DEADTIME_EN
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYC);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

  logic [DEAD_W-1:0] dead_q [NUM_CH];
  logic [DEAD_W-1:0] dead_d [NUM_CH];
`endif

  always_comb begin
    rel_edge  = release_req & ~release_q;
    release_d = release_req;
    coil_d    = coil_q;
    busy_d    = busy_q;
    done_d    = '0;
    rev_d     = rev_q;
    in_dead   = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c]  = state_q[c];
      period_d[c] = period_q[c];
      cnt_d[c]    = cnt_q[c];
`ifdef EM_DEADTIME_EN
      dead_d[c]   = dead_q[c];
      in_dead     = (dead_q[c] != '0);
`else
      in_dead     = 1'b0;
`endif

      // hold_req overrides every state; a coincident release edge is simply dropped
      if (hold_req[c]) begin
        state_d[c]      = ST_HOLD;
        coil_d[2*c +: 2] = COIL_FWD;
        busy_d[c]       = 1'b0;
        cnt_d[c]        = '0;
        period_d[c]     = '0;
`ifdef EM_DEADTIME_EN
        dead_d[c]       = '0;
`endif
      end else begin
        unique case (state_q[c])
          ST_OFF, ST_HOLD: begin
            if (rel_edge[c]) begin
              state_d[c]       = ST_DEGAUSS;
              period_d[c]      = PERIOD_INIT;
              cnt_d[c]         = '0;
              rev_d[c]         = 1'b1;
              busy_d[c]        = 1'b1;
              coil_d[2*c +: 2] = COIL_REV;
`ifdef EM_DEADTIME_EN
              // bridge is already off when leaving OFF, so only HOLD needs the gap
              if (state_q[c] == ST_HOLD && DEAD_CYC > 0) begin
                coil_d[2*c +: 2] = COIL_OFF;
                dead_d[c]        = DEAD_INIT;
              end
`endif
            end
          end

          ST_DEGAUSS: begin
            if (in_dead) begin
`ifdef EM_DEADTIME_EN
              dead_d[c] = dead_q[c] - DEAD_ONE;
              if (dead_q[c] == DEAD_ONE) begin
                coil_d[2*c +: 2] = rev_q[c] ? COIL_REV : COIL_FWD;
              end
`endif
            end else if (cnt_q[c] == period_q[c] - CNT_ONE) begin
              // compare before subtracting so the period can never wrap or reach zero
              if (period_q[c] > PERIOD_STEP) begin
                rev_d[c]         = ~rev_q[c];
                period_d[c]      = period_q[c] - PERIOD_STEP;
                cnt_d[c]         = '0;
                coil_d[2*c +: 2] = rev_q[c] ? COIL_FWD : COIL_REV;
`ifdef EM_DEADTIME_EN
                if (DEAD_CYC > 0) begin
                  coil_d[2*c +: 2] = COIL_OFF;
                  dead_d[c]        = DEAD_INIT;
                end
`endif
              end else begin
                state_d[c]       = ST_OFF;
                coil_d[2*c +: 2] = COIL_OFF;
                busy_d[c]        = 1'b0;
                done_d[c]        = 1'b1;
                cnt_d[c]         = '0;
                period_d[c]      = '0;
              end
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
          end

          default: begin
            state_d[c]       = ST_OFF;
            coil_d[2*c +: 2] = COIL_OFF;
            busy_d[c]        = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= ST_OFF;
        period_q[c] <= '0;
        cnt_q[c]    <= '0;
`ifdef EM_DEADTIME_EN
        dead_q[c]   <= '0;
`endif
      end
      rev_q     <= '0;
      release_q <= '1;
      busy_q    <= '0;
      done_q    <= '0;
      coil_q    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c]  <= state_d[c];
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
`ifdef EM_DEADTIME_EN
        dead_q[c]   <= dead_d[c];
`endif
      end
      rev_q     <= rev_d;
      release_q <= release_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      coil_q    <= coil_d;
    end
  end

  assign coil = coil_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_em_degauss_driver.sv
// Scoreboard bench for em_degauss_driver: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares. Expected degauss waveforms are hand-written run tables.
`timescale 1ns/1ps
module tb_em_degauss_driver;

  localparam int NUM_CH       = 2;
  localparam int CNT_W        = 8;
  localparam int START_PERIOD = 10;
  localparam int STEP         = 3;
  localparam int DEAD_CYC     = 2;

`ifdef EM_DEADTIME_EN
  localparam int NR    = 8;
  localparam int TOTAL = 30;
  localparam int         RUN_LEN  [NR] = '{2, 10, 2, 7, 2, 4, 2, 1};
  localparam logic [1:0] RUN_COIL [NR] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`else
  localparam int NR    = 4;
  localparam int TOTAL = 22;
  localparam int         RUN_LEN  [NR] = '{10, 7, 4, 1};
  localparam logic [1:0] RUN_COIL [NR] = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_CH-1:0]   hold_req = '0;
  logic [NUM_CH-1:0]   release_req = '1;
  logic [2*NUM_CH-1:0] coil;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   done;

  always #5 clk = ~clk;

  em_degauss_driver #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .START_PERIOD (START_PERIOD),
    .STEP         (STEP),
    .DEAD_CYC     (DEAD_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_req    (hold_req),
    .release_req (release_req),
    .coil        (coil),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    int         cyc;
    logic [3:0] coil;
    logic [1:0] busy;
    logic [1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference state per channel: ek = cycles since the release edge (0 = not degaussing)
  int         ek      [NUM_CH];
  logic [1:0] st_coil [NUM_CH];
  logic [1:0] prev_rel = 2'b11;
  int         cycle = 0;

  function automatic logic [1:0] deg_coil(input int k);
    int acc;
    acc = 0;
    for (int i = 0; i < NR; i++) begin
      acc += RUN_LEN[i];
      if (k <= acc) return RUN_COIL[i];
    end
    return 2'b00;
  endfunction

  task automatic tick(input logic [1:0] h, input logic [1:0] r);
    exp_t       e;
    logic [1:0] edge_v;
    hold_req    = h;
    release_req = r;
    edge_v      = r & ~prev_rel;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        ek[c]      = 0;
        st_coil[c] = 2'b00;
      end else if (h[c]) begin
        st_coil[c] = 2'b01;
        ek[c]      = 0;
      end else if (ek[c] >= 1 && ek[c] <= TOTAL) begin
        ek[c]++;
      end else begin
        if (ek[c] == TOTAL + 1) begin
          st_coil[c] = 2'b00;
          ek[c]      = 0;
        end
        if (edge_v[c]) ek[c] = 1;
      end
    end
    prev_rel = rst_n ? r : 2'b11;
    @(posedge clk);
    #1;
    e.cyc  = cycle;
    e.coil = '0;
    e.busy = '0;
    e.done = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ek[c] >= 1 && ek[c] <= TOTAL) begin
        e.coil[2*c +: 2] = deg_coil(ek[c]);
        e.busy[c]        = 1'b1;
      end else if (ek[c] == TOTAL + 1) begin
        e.done[c] = 1'b1;
      end else begin
        e.coil[2*c +: 2] = st_coil[c];
      end
    end
    exp_q.push_back(e);
    cycle++;
  endtask

  task automatic ticks(input logic [1:0] h, input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) tick(h, r);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (coil !== e.coil) begin
          n_errors++;
          $display("FAIL coil cyc=%0d got=%b want=%b", e.cyc, coil, e.coil);
        end
        n_checks++;
        if (busy !== e.busy) begin
          n_errors++;
          $display("FAIL busy cyc=%0d got=%b want=%b", e.cyc, busy, e.busy);
        end
        n_checks++;
        if (done !== e.done) begin
          n_errors++;
          $display("FAIL done cyc=%0d got=%b want=%b", e.cyc, done, e.done);
        end
      end
    end
  end

  initial begin : stimulus
    for (int c = 0; c < NUM_CH; c++) begin
      ek[c]      = 0;
      st_coil[c] = 2'b00;
    end
    // reset with release held high, then leave reset with it still high
    ticks(2'b00, 2'b11, 3);
    rst_n = 1'b1;
    ticks(2'b00, 2'b11, 3);
    ticks(2'b00, 2'b00, 2);

    // one-cycle hold pulse latches channel 0
    tick(2'b01, 2'b00);
    ticks(2'b00, 2'b00, 5);

    // full degauss from HOLD, with a re-trigger attempt mid-sequence
    tick(2'b00, 2'b01);
    ticks(2'b00, 2'b00, 3);
    tick(2'b00, 2'b01);
    ticks(2'b00, 2'b00, TOTAL + 3);

    // abort by hold at cycle 12 of the degauss
    tick(2'b01, 2'b00);
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b01);
    ticks(2'b00, 2'b00, 10);
    tick(2'b01, 2'b00);
    ticks(2'b00, 2'b00, 5);

    // abort on the very first degauss cycle
    tick(2'b00, 2'b01);
    tick(2'b01, 2'b00);
    ticks(2'b00, 2'b00, 3);

    // both channels, release edges 5 cycles apart
    tick(2'b11, 2'b00);
    tick(2'b00, 2'b00);
    tick(2'b00, 2'b01);
    ticks(2'b00, 2'b01, 4);
    tick(2'b00, 2'b11);
    ticks(2'b00, 2'b00, TOTAL + 8);

    // hold and release edge together on channel 1: hold wins, edge is consumed
    tick(2'b10, 2'b10);
    ticks(2'b00, 2'b10, 4);
    ticks(2'b00, 2'b00, 2);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
